logic_reduce_unit: RTL

- Parametrised, sequential successor to the fixed 32-bit bitwise OR used in the multi-cycle datapath.
- Reduces a stream of N operands (N chosen per transaction) with a selectable bitwise op: OR, AND, XOR or NOR.
- Operands arrive over a valid/ready handshake; the result leaves over a second valid/ready handshake.
- Used by multi-cycle CPU extensions for mask building and parity/flag reduction across register bursts.

---
 rtl/logic_reduce_unit_pkg.sv | 22 ++
 rtl/logic_reduce_unit_op_comb.sv | 27 ++
 rtl/logic_reduce_unit.sv | 110 +++++++++++
 3 files changed

// File: rtl/logic_reduce_unit_pkg.sv
// Shared encodings for the logic reduction unit and the CPU control unit.
package logic_reduce_unit_pkg;

  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_e;

  // NOR folds as OR; only the final result is inverted.
  function automatic logic op_inverts(input logic [1:0] op);
    return op == OP_NOR;
  endfunction

endpackage

// File: rtl/logic_reduce_unit_op_comb.sv
// Combinational bitwise a OP b with optional output inversion.
module logic_op_comb
  import logic_reduce_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             invert,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] raw;

  // Select the bitwise function; NOR shares the OR path and relies on invert.
  always_comb begin
    raw = a | b;
    case (op)
      OP_AND:  raw = a & b;
      OP_XOR:  raw = a ^ b;
      default: raw = a | b;
    endcase
    y = invert ? ~raw : raw;
  end

endmodule

// File: rtl/logic_reduce_unit.sv
// Sequential N-operand bitwise reduction (OR/AND/XOR/NOR) with
// valid/ready handshakes on both the operand and result sides.
module logic_reduce_unit
  import logic_reduce_unit_pkg::*;
#(
  parameter  int WIDTH     = 32,
  parameter  int MAX_BEATS = 8,
  localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] beats,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             err
);

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] beats_q;
  logic [WIDTH-1:0] out_data_q;
  logic             err_q;

  logic [WIDTH-1:0] step_y;
  logic [WIDTH-1:0] fin_y;
  logic             beats_ok;
  logic             accept;
  logic             last_beat;

  // Running accumulation: never inverted so NOR keeps folding as OR.
  logic_op_comb #(.WIDTH(WIDTH)) step_u (
    .a      (acc_q),
    .b      (in_data),
    .op     (op_q),
    .invert (1'b0),
    .y      (step_y)
  );

  // Final value including the NOR inversion, captured on the last beat.
  logic_op_comb #(.WIDTH(WIDTH)) fin_u (
    .a      (acc_q),
    .b      (in_data),
    .op     (op_q),
    .invert (op_inverts(op_q)),
    .y      (fin_y)
  );

  assign beats_ok  = (beats != '0) && (beats <= CNT_W'(MAX_BEATS));
  assign in_ready  = (state_q == ACCUM);
  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt_q == beats_q - CNT_W'(1));
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_data_q;
  assign err       = err_q;

  // Control FSM with counter, accumulator and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      op_q       <= OP_OR;
      beats_q    <= '0;
      out_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (beats_ok) begin
              op_q    <= op;
              beats_q <= beats;
              cnt_q   <= '0;
              acc_q   <= (op == OP_AND) ? '1 : '0;
              state_q <= ACCUM;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_q <= step_y;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_beat) begin
              out_data_q <= fin_y;
              state_q    <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
